instr_fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of `Single_Cycle_Core`. It takes the core's `PC`, returns the 32-bit `Instr` from a two-entry instruction buffer, and signals `InstrValid` so the core advances only on valid instructions. Misses are serviced over a valid/ready request/response port to instruction memory, with next-sequential (`PC+4`) prefetch.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/ibuf_2way.sv | 76 +++++++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared fetch-stage constants, state encoding and helpers.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   // Buffer tags are word addresses; byte offset bits are never stored.
   function automatic logic [XLEN-1:2] word_tag(input logic [XLEN-1:0] addr);
      return addr[XLEN-1:2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ibuf_2way.sv
`default_nettype none
// ============================================================================
// Module   : ibuf_2way
// Brief    : Two-entry instruction buffer with tag compare, LRU and fill port.
// Revision : 1.0
// ============================================================================
module ibuf_2way
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic [XLEN-1:2] lookup_tag,
   input  logic [XLEN-1:2] probe_tag,
   input  logic            lru_upd,
   input  logic            wr_en,
   input  logic            wr_way,
   input  logic [XLEN-1:2] wr_tag,
   input  logic [XLEN-1:0] wr_data,
   output logic            hit,
   output logic            hit_way,
   output logic            probe_hit,
   output logic            lru,
   output logic [XLEN-1:0] rd_data
);

   logic [1:0]      r_valid;
   logic [XLEN-1:2] r_tag  [2];
   logic [XLEN-1:0] r_data [2];
   logic            r_lru;

   logic [1:0]      w_match;
   logic [1:0]      w_probe;

   always_comb begin
      w_match = 2'b00;
      w_probe = 2'b00;
      for (int i = 0; i < 2; i++) begin
         w_match[i] = r_valid[i] && (r_tag[i] == lookup_tag);
         w_probe[i] = r_valid[i] && (r_tag[i] == probe_tag);
      end
   end

   // A tag is only ever resident in one way, so way 1 alone decides hit_way.
   assign hit       = |w_match;
   assign hit_way   = w_match[1];
   assign probe_hit = |w_probe;
   assign lru       = r_lru;
   assign rd_data   = w_match[1] ? r_data[1] : r_data[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else if (flush) begin
         r_valid <= 2'b00;
      end else if (wr_en) begin
         r_valid[wr_way] <= 1'b1;
         r_tag[wr_way]   <= wr_tag;
         r_data[wr_way]  <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lru <= 1'b0;
      end else if (lru_upd && hit) begin
         r_lru <= ~hit_way;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Buffered instruction fetch with miss handling and PC+4 prefetch.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
   parameter bit              PREFETCH_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] Instr,
   output logic            InstrValid,
   output logic            InstrFault,
   input  logic            InstrFlush,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data
);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_req_addr;
   logic            r_fill_way;
   logic            r_drop;

   logic            w_load;
   logic [XLEN-1:0] w_load_addr;
   logic            w_load_way;
   logic            w_drop_nxt;
   logic            w_wr_en;

   logic            w_fault;
   logic            w_hit;
   logic            w_hit_way;
   logic            w_probe_hit;
   logic            w_lru;
   logic [XLEN-1:0] w_rd_data;
   logic [XLEN-1:2] w_probe_tag;

   assign w_fault     = (PC[1:0] != 2'b00);
   // Tag increment wraps naturally, so 0xFFFF_FFFC probes address 0.
   assign w_probe_tag = word_tag(PC) + 30'd1;

   ibuf_2way u_ibuf (
      .clk        (clk),
      .reset      (reset),
      .flush      (InstrFlush),
      .lookup_tag (word_tag(PC)),
      .probe_tag  (w_probe_tag),
      .lru_upd    (~w_fault),
      .wr_en      (w_wr_en),
      .wr_way     (r_fill_way),
      .wr_tag     (word_tag(r_req_addr)),
      .wr_data    (imem_rsp_data),
      .hit        (w_hit),
      .hit_way    (w_hit_way),
      .probe_hit  (w_probe_hit),
      .lru        (w_lru),
      .rd_data    (w_rd_data)
   );

   assign InstrFault = w_fault;
   assign InstrValid = w_hit && !w_fault;
   assign Instr      = InstrValid ? w_rd_data : NOP_INSTR;

   // Flush withdraws the request in the same cycle so memory never accepts
   // a transaction whose response would arrive outside WAIT.
   assign imem_req_valid = (r_state == REQ) && !InstrFlush;
   assign imem_req_addr  = r_req_addr;

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_addr = r_req_addr;
      w_load_way  = r_fill_way;
      w_drop_nxt  = r_drop;
      w_wr_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fault) begin
               if (!w_hit) begin
                  w_load      = 1'b1;
                  w_load_addr = {PC[XLEN-1:2], 2'b00};
                  w_load_way  = w_lru;
                  w_state_nxt = REQ;
               end else if (PREFETCH_EN && !w_probe_hit) begin
                  w_load      = 1'b1;
                  w_load_addr = {w_probe_tag, 2'b00};
                  w_load_way  = ~w_hit_way;
                  w_state_nxt = REQ;
               end
            end
         end
         REQ: begin
            if (InstrFlush) begin
               w_state_nxt = IDLE;
            end else if (imem_req_ready) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               w_wr_en     = !r_drop && !InstrFlush;
               w_drop_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else if (InstrFlush) begin
               w_drop_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_drop_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_req_addr <= RESET_PC;
         r_fill_way <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_drop_nxt;
         if (w_load) begin
            r_req_addr <= w_load_addr;
            r_fill_way <= w_load_way;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] D0  = 32'h0040_0093;
   localparam logic [31:0] D4  = 32'h0080_80b3;
   localparam logic [31:0] D8  = 32'h00c0_0113;
   localparam logic [31:0] DZ  = 32'h0010_0193;
   localparam logic [31:0] D100 = 32'h0020_0213;
   localparam logic [31:0] DW  = 32'h0000_0073;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PC;
   logic [31:0] Instr;
   logic        InstrValid;
   logic        InstrFault;
   logic        InstrFlush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] pc;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [7];

   instr_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .PREFETCH_EN (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .PC             (PC),
      .Instr          (Instr),
      .InstrValid     (InstrValid),
      .InstrFault     (InstrFault),
      .InstrFlush     (InstrFlush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_req(input string name, input logic [31:0] addr);
      #1;
      chk({name, " req_valid"}, {31'd0, imem_req_valid}, 32'd1);
      chk({name, " req_addr"}, imem_req_addr, addr);
   endtask

   task automatic chk_out(input string name, input logic v, input logic [31:0] ins);
      #1;
      chk({name, " valid"}, {31'd0, InstrValid}, {31'd0, v});
      chk({name, " instr"}, Instr, ins);
   endtask

   task automatic chk_noreq(input string name);
      #1;
      chk({name, " no req"}, {31'd0, imem_req_valid}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{pc: 32'h0000_0004, exp_valid: 1'b1, exp_instr: D4,  exp_fault: 1'b0};
      vecs[1] = '{pc: 32'h0000_0008, exp_valid: 1'b1, exp_instr: D8,  exp_fault: 1'b0};
      vecs[2] = '{pc: 32'h0000_0000, exp_valid: 1'b0, exp_instr: NOP, exp_fault: 1'b0};
      vecs[3] = '{pc: 32'h0000_0006, exp_valid: 1'b0, exp_instr: NOP, exp_fault: 1'b1};
      vecs[4] = '{pc: 32'h0000_0005, exp_valid: 1'b0, exp_instr: NOP, exp_fault: 1'b1};
      vecs[5] = '{pc: 32'h0000_000C, exp_valid: 1'b0, exp_instr: NOP, exp_fault: 1'b0};
      vecs[6] = '{pc: 32'h0001_0004, exp_valid: 1'b0, exp_instr: NOP, exp_fault: 1'b0};

      reset = 1'b0; PC = 32'h2; InstrFlush = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      step();
      #1;
      chk("reset fault tracks PC", {31'd0, InstrFault}, 32'd1);
      PC = 32'h0;
      chk_out("reset", 1'b0, NOP);
      chk_noreq("reset");
      step();
      reset = 1'b1;

      // Cold miss: request in cycle 1, data valid in cycle 3.
      step(); chk_req("cold", 32'h0); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = D0;
      chk_noreq("cold wait"); chk_out("cold wait", 1'b0, NOP);
      step(); imem_rsp_valid = 1'b0; chk_out("cold fill", 1'b1, D0);
      step(); chk_req("prefetch4", 32'h4); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = D4;
      step(); imem_rsp_valid = 1'b0; chk_out("pc0 after pf", 1'b1, D0); chk_noreq("pf done");
      step(); chk_noreq("pf resident");
      PC = 32'h4; chk_out("seq pc4", 1'b1, D4);
      step(); chk_req("prefetch8", 32'h8); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = D8;
      step(); imem_rsp_valid = 1'b0; chk_noreq("pf8 done"); chk_out("pc4 held", 1'b1, D4);

      // Combinational lookups against {way0: 0x8, way1: 0x4}, no clock edges.
      for (int i = 0; i < 7; i++) begin
         PC = vecs[i].pc;
         #1;
         chk($sformatf("vec%0d valid", i), {31'd0, InstrValid}, {31'd0, vecs[i].exp_valid});
         chk($sformatf("vec%0d instr", i), Instr, vecs[i].exp_instr);
         chk($sformatf("vec%0d fault", i), {31'd0, InstrFault}, {31'd0, vecs[i].exp_fault});
      end
      PC = 32'h4;
      #1;

      // Misaligned PC never requests.
      PC = 32'h2;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("misalign fault", {31'd0, InstrFault}, 32'd1);
         chk_out("misalign", 1'b0, NOP);
         chk_noreq("misalign");
      end

      // PC changes while the fill for 0 is outstanding.
      PC = 32'h0;
      step(); chk_req("miss0", 32'h0); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; PC = 32'h100;
      chk_noreq("wait0 a"); chk_out("wait0 a", 1'b0, NOP);
      step(); chk_noreq("wait0 b"); chk_out("wait0 b", 1'b0, NOP);
      step(); chk_noreq("wait0 c");
      imem_rsp_valid = 1'b1; imem_rsp_data = DZ;
      step(); imem_rsp_valid = 1'b0;
      PC = 32'h0; chk_out("entry0 filled", 1'b1, DZ);
      PC = 32'h100; chk_out("pc100 miss", 1'b0, NOP);
      step(); chk_req("miss100", 32'h100); chk_out("miss100", 1'b0, NOP);
      imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = D100;
      step(); imem_rsp_valid = 1'b0; chk_out("fill100", 1'b1, D100);

      // Flush while waiting for the 0x104 prefetch.
      step(); chk_req("prefetch104", 32'h104); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; InstrFlush = 1'b1;
      chk_noreq("flush wait");
      step(); InstrFlush = 1'b0; chk_out("flushed", 1'b0, NOP);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step(); imem_rsp_valid = 1'b0; chk_out("dropped", 1'b0, NOP);
      PC = 32'h104; chk_out("dropped104", 1'b0, NOP);
      PC = 32'h100; #1;
      step(); chk_req("rereq100", 32'h100); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = D100;
      step(); imem_rsp_valid = 1'b0; chk_out("refill100", 1'b1, D100);

      // Asynchronous reset in the middle of an unaccepted request.
      step(); chk_req("pf104 again", 32'h104);
      step(); chk_req("pf104 held", 32'h104);
      #2 reset = 1'b0;
      #1;
      chk("async reset req", {31'd0, imem_req_valid}, 32'd0);
      chk_out("async reset", 1'b0, NOP);

      // Wrap: a hit on 0xFFFF_FFFC prefetches address 0.
      PC = 32'hFFFF_FFFC;
      step(); step(); reset = 1'b1;
      step(); chk_req("wrap miss", 32'hFFFF_FFFC); imem_req_ready = 1'b1;
      step(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = DW;
      step(); imem_rsp_valid = 1'b0; chk_out("wrap fill", 1'b1, DW);
      chk("wrap fault", {31'd0, InstrFault}, 32'd0);
      step(); chk_req("wrap prefetch", 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
